// File: rtl/dmem_responder_pkg.sv
// dmem_responder_pkg
// Shared definitions for the data-memory responder: FSM state encoding,
// latency counter width and the default array depth.
// Optional feature macro used by the slice: DMEM_RANGE_CHECK_EN.

package dmem_responder_pkg;

   localparam int unsigned DMEM_CNT_W         = 4;
   localparam int unsigned DMEM_DEFAULT_DEPTH = 1024;

   typedef enum logic [2:0] {
      DMEM_IDLE  = 3'd0,
      DMEM_GRANT = 3'd1,
      DMEM_BUSY  = 3'd2,
      DMEM_RESP  = 3'd3,
      DMEM_TURN  = 3'd4
   } dmem_state_e;

endpackage

// File: rtl/dmem_responder_if.sv
// dmem_responder_if
// Memory request bus between the load/store initiator and the data-memory
// responder.
//   req_valid/addr/we/wrt_data : initiator -> responder
//   grant/data_valid/rd_data   : responder -> initiator
//   addr_err                   : responder -> initiator, only with DMEM_RANGE_CHECK_EN
// Modports: master (initiator side), slave (responder side).

interface dmem_responder_if #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 32
);

   logic                  req_valid;
   logic [ADDR_WIDTH-1:0] addr;
   logic                  we;
   logic [DATA_WIDTH-1:0] wrt_data;
   logic                  grant;
   logic                  data_valid;
   logic [DATA_WIDTH-1:0] rd_data;
`ifdef DMEM_RANGE_CHECK_EN
   logic                  addr_err;

   modport master (
      output req_valid, addr, we, wrt_data,
      input  grant, data_valid, rd_data, addr_err
   );

   modport slave (
      input  req_valid, addr, we, wrt_data,
      output grant, data_valid, rd_data, addr_err
   );
`else
   modport master (
      output req_valid, addr, we, wrt_data,
      input  grant, data_valid, rd_data
   );

   modport slave (
      input  req_valid, addr, we, wrt_data,
      output grant, data_valid, rd_data
   );
`endif

endinterface

// File: rtl/dmem_array.sv
// dmem_array
// Single-port synchronous RAM, MEM_DEPTH x DATA_WIDTH, no reset on contents.
//   clk   : clock
//   en    : access strobe for this edge
//   we    : 1 = write wdata to index, 0 = read index into rdata
//   index : word index
//   wdata : write data
//   rdata : registered read data (holds its value when not reading)

module dmem_array #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned MEM_DEPTH  = 1024,
   parameter int unsigned IDX_W      = $clog2(MEM_DEPTH)
) (
   input  logic                  clk,
   input  logic                  en,
   input  logic                  we,
   input  logic [IDX_W-1:0]      index,
   input  logic [DATA_WIDTH-1:0] wdata,
   output logic [DATA_WIDTH-1:0] rdata
);

   logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];
   logic [DATA_WIDTH-1:0] rdata_q;

   always_ff @(posedge clk) begin
      if (en) begin
         if (we) begin
            mem_q[index] <= wdata;
         end else begin
            rdata_q <= mem_q[index];
         end
      end
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder
// Responder end of the core's memory request bus: accepts one request at a
// time, pulses grant the cycle after capture, then pulses data_valid LATENCY
// cycles later with the load word (0 for stores). One TURN cycle follows each
// response so the initiator's req_valid deassertion is not taken as a new
// request.
//   clk   : clock, rising edge
//   reset : synchronous, active-high
//   bus   : dmem_responder_if.slave (request in, grant/data_valid/rd_data out)
// Optional macro DMEM_RANGE_CHECK_EN: out-of-range captured addresses drop the
// store / read as 0 and raise bus.addr_err during the data_valid cycle.

import dmem_responder_pkg::*;

module dmem_responder #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned MEM_DEPTH  = DMEM_DEFAULT_DEPTH,
   parameter int unsigned LATENCY    = 2
) (
   input  logic           clk,
   input  logic           reset,
   dmem_responder_if.slave bus
);

   localparam int unsigned IDX_W = $clog2(MEM_DEPTH);

   dmem_state_e           state_q, state_d;
   logic [DMEM_CNT_W-1:0] cnt_q, cnt_d;
   logic [IDX_W-1:0]      idx_q, idx_d;
   logic                  we_q, we_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic                  grant_q, grant_d;
   logic                  dv_q, dv_d;
   logic                  enter_resp;
   logic                  ram_en;
   logic                  ram_we;
   logic [DATA_WIDTH-1:0] ram_rdata;
   logic                  oob_q, oob_d;

`ifdef DMEM_RANGE_CHECK_EN
   localparam logic [ADDR_WIDTH:0] ADDR_LIMIT = (ADDR_WIDTH+1)'(MEM_DEPTH) << 2;
   logic err_q, err_d;
`endif

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      idx_d      = idx_q;
      we_d       = we_q;
      wdata_d    = wdata_q;
      oob_d      = oob_q;
      grant_d    = 1'b0;
      enter_resp = 1'b0;
      unique case (state_q)
         DMEM_IDLE: begin
            if (bus.req_valid) begin
               idx_d   = bus.addr[IDX_W+1:2];
               we_d    = bus.we;
               wdata_d = bus.wrt_data;
`ifdef DMEM_RANGE_CHECK_EN
               oob_d   = ({1'b0, bus.addr} >= ADDR_LIMIT);
`else
               oob_d   = 1'b0;
`endif
               grant_d = 1'b1;
               state_d = DMEM_GRANT;
            end
         end
         DMEM_GRANT: begin
            if (LATENCY == 1) begin
               enter_resp = 1'b1;
               state_d    = DMEM_RESP;
            end else begin
               cnt_d   = DMEM_CNT_W'(LATENCY - 1);
               state_d = DMEM_BUSY;
            end
         end
         DMEM_BUSY: begin
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == DMEM_CNT_W'(1)) begin
               enter_resp = 1'b1;
               state_d    = DMEM_RESP;
            end
         end
         DMEM_RESP: state_d = DMEM_TURN;
         DMEM_TURN: state_d = DMEM_IDLE;
         default:   state_d = DMEM_IDLE;
      endcase
      dv_d = enter_resp;
`ifdef DMEM_RANGE_CHECK_EN
      err_d = enter_resp & oob_q;
`endif
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= DMEM_IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         we_q    <= 1'b0;
         wdata_q <= '0;
         oob_q   <= 1'b0;
         grant_q <= 1'b0;
         dv_q    <= 1'b0;
`ifdef DMEM_RANGE_CHECK_EN
         err_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         we_q    <= we_d;
         wdata_q <= wdata_d;
         oob_q   <= oob_d;
         grant_q <= grant_d;
         dv_q    <= dv_d;
`ifdef DMEM_RANGE_CHECK_EN
         err_q   <= err_d;
`endif
      end
   end

   // Reset on the RESP-entry edge must also block the array access, otherwise
   // an aborted store would still commit.
   assign ram_en = enter_resp & ~reset;
   assign ram_we = we_q & ~oob_q;

   dmem_array #(
      .DATA_WIDTH (DATA_WIDTH),
      .MEM_DEPTH  (MEM_DEPTH),
      .IDX_W      (IDX_W)
   ) u_array (
      .clk   (clk),
      .en    (ram_en),
      .we    (ram_we),
      .index (idx_q),
      .wdata (wdata_q),
      .rdata (ram_rdata)
   );

   assign bus.grant      = grant_q;
   assign bus.data_valid = dv_q;
   // RAM output is only meaningful for an in-range load during data_valid.
   assign bus.rd_data    = (dv_q && !we_q && !oob_q) ? ram_rdata : '0;
`ifdef DMEM_RANGE_CHECK_EN
   assign bus.addr_err   = err_q;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder
// Directed plus randomized bench for dmem_responder. Reference model is a plain
// word array indexed by (addr / 4) mod DEPTH; timing expectations follow from
// LATENCY (grant one cycle after the request edge, data_valid LATENCY cycles
// after grant, TURN then IDLE before the next grant).
// Honours DMEM_RANGE_CHECK_EN the same way as the design.

module tb_dmem_responder;

   localparam int unsigned DW    = 32;
   localparam int unsigned AW    = 32;
   localparam int unsigned DEPTH = 1024;
   localparam int unsigned LAT   = 2;

   logic clk;
   logic reset;
   int   checks;
   int   failures;

   logic [DW-1:0] mdl     [DEPTH];
   bit            written [DEPTH];

   dmem_responder_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

   dmem_responder #(
      .DATA_WIDTH (DW),
      .ADDR_WIDTH (AW),
      .MEM_DEPTH  (DEPTH),
      .LATENCY    (LAT)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_err(input string tag, input logic exp);
`ifdef DMEM_RANGE_CHECK_EN
      check(tag, {63'd0, bus.addr_err}, {63'd0, exp});
`else
      if (exp) check(tag, 64'd0, 64'd1);
`endif
   endtask

   // One complete transaction starting from an IDLE cycle. Returns after the
   // IDLE cycle that follows TURN, so a following call lines up with the
   // earliest legal re-grant.
   task automatic txn(input logic [AW-1:0] a, input logic w, input logic [DW-1:0] d,
                      input bit drop, input bit hold);
      logic [DW-1:0] exp_rd;
      bit            exp_err;
      bit            chk_rd;
      int            idx;
      exp_err = 1'b0;
      chk_rd  = 1'b1;
      exp_rd  = '0;
      idx     = int'((a >> 2) % DEPTH);
`ifdef DMEM_RANGE_CHECK_EN
      exp_err = (64'(a) >= 64'(DEPTH) * 4);
`endif
      if (w) begin
         if (!exp_err) begin
            mdl[idx]     = d;
            written[idx] = 1'b1;
         end
      end else if (!exp_err) begin
         if (written[idx]) exp_rd = mdl[idx];
         else chk_rd = 1'b0;
      end
      bus.req_valid = 1'b1;
      bus.addr      = a;
      bus.we        = w;
      bus.wrt_data  = d;
      for (int k = 1; k <= int'(LAT) + 3; k++) begin
         @(negedge clk);
         check("grant", {63'd0, bus.grant}, {63'd0, (k == 1)});
         check("data_valid", {63'd0, bus.data_valid}, {63'd0, (k == int'(LAT) + 1)});
         if (k == int'(LAT) + 1) begin
            if (chk_rd) check("rd_data", 64'(bus.rd_data), 64'(exp_rd));
            check_err("addr_err_resp", exp_err);
            if (!hold) bus.req_valid = 1'b0;
         end else begin
            check_err("addr_err_idle", 1'b0);
         end
         if (k == 1) begin
            // Captured inputs must win over anything driven after grant.
            bus.addr     = $urandom;
            bus.we       = 1'($urandom);
            bus.wrt_data = $urandom;
            if (drop) bus.req_valid = 1'b0;
         end
      end
   endtask

   initial begin
      logic [AW-1:0] a;
      checks        = 0;
      failures      = 0;
      reset         = 1'b1;
      bus.req_valid = 1'b0;
      bus.addr      = '0;
      bus.we        = 1'b0;
      bus.wrt_data  = '0;
      for (int i = 0; i < int'(DEPTH); i++) written[i] = 1'b0;

      repeat (3) @(negedge clk);
      check("reset_grant", {63'd0, bus.grant}, 64'd0);
      check("reset_data_valid", {63'd0, bus.data_valid}, 64'd0);
      check("reset_rd_data", 64'(bus.rd_data), 64'd0);
      check_err("reset_addr_err", 1'b0);
      reset = 1'b0;
      @(negedge clk);

      // Basic store / load, low address bits ignored.
      txn(32'h10, 1'b1, 32'hDEADBEEF, 1'b0, 1'b0);
      txn(32'h10, 1'b0, 32'h0, 1'b0, 1'b0);
      txn(32'h10, 1'b1, 32'h12345678, 1'b0, 1'b0);
      txn(32'h13, 1'b0, 32'h0, 1'b0, 1'b0);

      // req_valid dropped right after grant: transaction still completes.
      txn(32'h20, 1'b1, 32'hA5A5A5A5, 1'b1, 1'b0);
      txn(32'h20, 1'b0, 32'h0, 1'b0, 1'b0);

      // req_valid held through RESP/TURN: single pulses, re-grant at LAT+3 period.
      txn(32'h20, 1'b0, 32'h0, 1'b0, 1'b1);
      txn(32'h10, 1'b0, 32'h0, 1'b0, 1'b1);
      txn(32'h13, 1'b0, 32'h0, 1'b0, 1'b0);

      // Reset in BUSY of a store: no response, old value kept.
      txn(32'h40, 1'b1, 32'h11111111, 1'b0, 1'b0);
      bus.req_valid = 1'b1;
      bus.addr      = 32'h40;
      bus.we        = 1'b1;
      bus.wrt_data  = 32'h55;
      @(negedge clk);
      check("rst_busy_grant", {63'd0, bus.grant}, 64'd1);
      @(negedge clk);
      check("rst_busy_pre_dv", {63'd0, bus.data_valid}, 64'd0);
      reset         = 1'b1;
      bus.req_valid = 1'b0;
      @(negedge clk);
      check("rst_busy_grant0", {63'd0, bus.grant}, 64'd0);
      check("rst_busy_dv0", {63'd0, bus.data_valid}, 64'd0);
      check("rst_busy_rd0", 64'(bus.rd_data), 64'd0);
      reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("rst_busy_no_dv", {63'd0, bus.data_valid}, 64'd0);
         check("rst_busy_no_grant", {63'd0, bus.grant}, 64'd0);
      end
      txn(32'h40, 1'b0, 32'h0, 1'b0, 1'b0);

      // Address beyond the array: wraps to word 0, or flagged with range check.
      txn(32'h0, 1'b1, 32'hCAFEF00D, 1'b0, 1'b0);
      txn(32'h1000, 1'b0, 32'h0, 1'b0, 1'b0);
      txn(32'h1004, 1'b1, 32'h0BADC0DE, 1'b0, 1'b0);
      txn(32'h4, 1'b0, 32'h0, 1'b0, 1'b0);

      // Randomized mix over a small word set, with aliased upper address bits.
      for (int n = 0; n < 40; n++) begin
         a = (AW'($urandom_range(0, 3) == 0 ? $urandom_range(1, 7) : 0) << 12)
             | (AW'($urandom_range(0, 15)) << 2) | AW'($urandom_range(0, 3));
         txn(a, 1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
             ($urandom_range(0, 3) == 0));
      end
      bus.req_valid = 1'b0;
      @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
